// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - multi-cycle ALU stage: capture, load A, load shifted B, execute, write back
module alu_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] shift,
  input  logic [1:0] rn,
  input  logic [1:0] rm,
  input  logic [1:0] rd,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic [1:0] rd_addr_a,
  output logic [1:0] rd_addr_b,
  output logic       ready,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       Z,
  output logic       N,
  output logic       V
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] shift_q, shift_d;
  logic [1:0] rn_q, rn_d;
  logic [1:0] rm_q, rm_d;
  logic [1:0] rd_q, rd_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] c_q, c_d;
  logic       z_q, z_d;
  logic       n_q, n_d;
  logic       v_q, v_d;
  logic [1:0] wa_hold_q, wa_hold_d;
  logic [7:0] wd_hold_q, wd_hold_d;

  logic [7:0] b_shifted;
  logic [7:0] alu_c;
  logic       alu_v;

  always_comb begin
    b_shifted = data_b;
    case (shift_q)
      2'b01:   b_shifted = {data_b[6:0], 1'b0};
      2'b10:   b_shifted = {1'b0, data_b[7:1]};
      2'b11:   b_shifted = {data_b[7], data_b[7:1]};
      default: b_shifted = data_b;
    endcase
  end

  // Overflow: operands of like sign (ADD) or unlike sign (SUB) yielding a result whose sign differs from A.
  always_comb begin
    alu_c = 8'h00;
    alu_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_c = a_q + b_q;
        alu_v = (a_q[7] == b_q[7]) && (alu_c[7] != a_q[7]);
      end
      OP_SUB: begin
        alu_c = a_q - b_q;
        alu_v = (a_q[7] != b_q[7]) && (alu_c[7] != a_q[7]);
      end
      OP_AND:  alu_c = a_q & b_q;
      OP_MVN:  alu_c = ~b_q;
      default: alu_c = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    shift_d   = shift_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    v_d       = v_q;
    wa_hold_d = wa_hold_q;
    wd_hold_d = wd_hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          shift_d = shift;
          rn_d    = rn;
          rm_d    = rm;
          rd_d    = rd;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        a_d     = data_a;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d     = b_shifted;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d     = alu_c;
        z_d     = (alu_c == 8'h00);
        n_d     = alu_c[7];
        v_d     = alu_v;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wa_hold_d = rd_q;
        wd_hold_d = c_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      shift_q   <= 2'b00;
      rn_q      <= 2'b00;
      rm_q      <= 2'b00;
      rd_q      <= 2'b00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      c_q       <= 8'h00;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      wa_hold_q <= 2'b00;
      wd_hold_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      shift_q   <= shift_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      z_q       <= z_d;
      n_q       <= n_d;
      v_q       <= v_d;
      wa_hold_q <= wa_hold_d;
      wd_hold_q <= wd_hold_d;
    end
  end

  // Write-back port shows the previous write outside WRITE, so a fresh C never leaks early.
  assign ready     = (state_q == S_IDLE);
  assign wr_en     = (state_q == S_WRITE);
  assign wr_addr   = wr_en ? rd_q : wa_hold_q;
  assign wr_data   = wr_en ? c_q  : wd_hold_q;
  assign rd_addr_a = rn_q;
  assign rd_addr_b = rm_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - randomized and directed checks of alu_stage against an arithmetic reference model
module tb_alu_stage;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] op, shift, rn, rm, rd;
  logic [7:0] data_a, data_b;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic       ready, wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       Z, N, V;

  always #5 clk = ~clk;

  alu_stage dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
    .rn(rn), .rm(rm), .rd(rd), .data_a(data_a), .data_b(data_b),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .Z(Z), .N(N), .V(V)
  );

  logic [7:0] rf [4];
  logic       pl_en;
  logic [1:0] pl_addr;
  logic [7:0] pl_data;

  assign data_a = rf[rd_addr_a];
  assign data_b = rf[rd_addr_b];

  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  int total = 0;
  int bad   = 0;

  logic [2:0] prev_fl;
  logic [1:0] prev_wa;
  logic [7:0] prev_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {V, N, Z, C[7:0]} from signed/unsigned integer arithmetic.
  function automatic logic [10:0] ref_alu(input logic [1:0] o, input logic [1:0] sh,
                                          input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r;
    logic v;
    logic [7:0] c;
    ub = b;
    sb = (ub >= 128) ? ub - 256 : ub;
    case (sh)
      2'd1: ub = (ub * 2) % 256;
      2'd2: ub = ub / 2;
      2'd3: ub = ((sb - ((sb % 2 != 0) ? 1 : 0)) / 2) & 255;
      default: ;
    endcase
    sb = (ub >= 128) ? ub - 256 : ub;
    ua = a;
    sa = (ua >= 128) ? ua - 256 : ua;
    v = 1'b0;
    case (o)
      2'd0: begin r = sa + sb; v = (r > 127) || (r < -128); end
      2'd1: begin r = sa - sb; v = (r > 127) || (r < -128); end
      2'd2: r = ua & ub;
      default: r = 255 - ub;
    endcase
    c = 8'(r & 255);
    return {v, c[7], (c == 8'h00), c};
  endfunction

  task automatic preload(input logic [1:0] addr, input logic [7:0] val);
    pl_en = 1'b1; pl_addr = addr; pl_data = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge while idle; returns at the negedge of the cycle after WRITE.
  task automatic run_op(input logic [1:0] o, input logic [1:0] sh, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] d, input bit poke,
                        output logic [7:0] got_wd, output logic [2:0] got_fl);
    logic [10:0] r;
    r = ref_alu(o, sh, rf[a], rf[b]);
    chk("ready_idle", ready, 1'b1);
    start = 1'b1; op = o; shift = sh; rn = a; rm = b; rd = d;
    @(negedge clk);
    start = 1'b0;
    chk("ready_busy", ready, 1'b0);
    chk("wr_en_c1", wr_en, 1'b0);
    chk("rd_addr_a", rd_addr_a, a);
    chk("rd_addr_b", rd_addr_b, b);
    chk("flags_hold_c1", {V, N, Z}, prev_fl);
    @(negedge clk);
    chk("wr_en_c2", wr_en, 1'b0);
    if (poke) begin
      start = 1'b1; op = ~o; shift = ~sh; rn = ~a; rm = ~b; rd = ~d;
    end
    @(negedge clk);
    start = 1'b0;
    chk("wr_en_c3", wr_en, 1'b0);
    chk("flags_hold_c3", {V, N, Z}, prev_fl);
    chk("wr_addr_hold_c3", wr_addr, prev_wa);
    chk("wr_data_hold_c3", wr_data, prev_wd);
    chk("rd_addr_a_kept", rd_addr_a, a);
    @(negedge clk);
    chk("wr_en_c4", wr_en, 1'b1);
    chk("wr_addr", wr_addr, d);
    chk("wr_data", wr_data, r[7:0]);
    chk("flags", {V, N, Z}, r[10:8]);
    got_wd = wr_data;
    got_fl = {V, N, Z};
    prev_fl = r[10:8];
    prev_wa = d;
    prev_wd = r[7:0];
    @(negedge clk);
    chk("wr_en_c5", wr_en, 1'b0);
    chk("ready_c5", ready, 1'b1);
    chk("wr_addr_hold_c5", wr_addr, prev_wa);
    chk("wr_data_hold_c5", wr_data, prev_wd);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_flags"}, {V, N, Z}, 3'b000);
    chk({tag, "_wr_data"}, wr_data, 8'h00);
    chk({tag, "_wr_addr"}, wr_addr, 2'b00);
    chk({tag, "_rd_addr_a"}, rd_addr_a, 2'b00);
    chk({tag, "_rd_addr_b"}, rd_addr_b, 2'b00);
    prev_fl = 3'b000; prev_wa = 2'b00; prev_wd = 8'h00;
  endtask

  initial begin
    logic [7:0] wd;
    logic [2:0] fl;
    reset = 1'b1; start = 1'b0; op = 2'b00; shift = 2'b00;
    rn = 2'b00; rm = 2'b00; rd = 2'b00;
    pl_en = 1'b0; pl_addr = 2'b00; pl_data = 8'h00;
    prev_fl = 3'b000; prev_wa = 2'b00; prev_wd = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");

    preload(2'd0, 8'h05); preload(2'd1, 8'h03); preload(2'd2, 8'hEE); preload(2'd3, 8'h44);
    run_op(2'b00, 2'b00, 2'd0, 2'd1, 2'd2, 1'b0, wd, fl);
    chk("v_add_basic", {fl, wd}, {3'b000, 8'h08});

    preload(2'd0, 8'h7F); preload(2'd1, 8'h01);
    run_op(2'b00, 2'b00, 2'd0, 2'd1, 2'd3, 1'b0, wd, fl);
    chk("v_add_ovf", {fl, wd}, {3'b110, 8'h80});
    preload(2'd2, 8'h80);
    run_op(2'b01, 2'b00, 2'd2, 2'd1, 2'd3, 1'b0, wd, fl);
    chk("v_sub_ovf", {fl, wd}, {3'b100, 8'h7F});

    preload(2'd0, 8'h2A);
    run_op(2'b01, 2'b00, 2'd0, 2'd0, 2'd3, 1'b0, wd, fl);
    chk("v_sub_zero", {fl, wd}, {3'b001, 8'h00});

    preload(2'd1, 8'h84);
    run_op(2'b11, 2'b11, 2'd0, 2'd1, 2'd3, 1'b0, wd, fl);
    chk("v_mvn_asr", {fl, wd}, {3'b000, 8'h3D});
    preload(2'd2, 8'hF0); preload(2'd3, 8'h3C);
    run_op(2'b10, 2'b01, 2'd2, 2'd3, 2'd0, 1'b1, wd, fl);
    chk("v_and_lsl_poked", {fl, wd}, {3'b000, 8'h70});

    preload(2'd1, 8'h10); preload(2'd0, 8'h01);
    run_op(2'b00, 2'b00, 2'd1, 2'd0, 2'd1, 1'b0, wd, fl);
    chk("v_rd_eq_rn", wd, 8'h11);
    run_op(2'b00, 2'b00, 2'd1, 2'd1, 2'd3, 1'b0, wd, fl);
    chk("v_back_to_back", wd, 8'h22);

    // Abandon an operation in EXEC.
    start = 1'b1; op = 2'b00; shift = 2'b00; rn = 2'd1; rm = 2'd2; rd = 2'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst_exec");
    @(negedge clk);
    chk("rst_exec_no_wr", wr_en, 1'b0);
    chk("rst_exec_idle", ready, 1'b1);

    // Reset wins over start on the same edge.
    reset = 1'b1; start = 1'b1; rn = 2'd3; rm = 2'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check_reset_state("rst_prio");
    @(negedge clk);
    chk("rst_prio_idle", ready, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) preload(2'($urandom_range(0, 3)), 8'($urandom));
      run_op(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), wd, fl);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
